register_array_filler: RTL
==========================

// Module: register_array_filler
// PURPOSE
//  Write-side producer for the register-array FIFO in the input buffer. Scans a pic_size x pic_size
//  feature map in SRAM with a 3x3 stride-1 window and emits each window as 9 dw-bit beats
//  (index 0..8 = ky*3+kx). Each window goes into FIFO slot bit = window_cnt[2:0].
//  Out-of-image taps are sent as zero-beats (write_rst=1) and are not read from SRAM.
// PARAMETERS
//  dw   128  data width of one beat (one pixel, all channels)
//  AW   12   SRAM word address width; pic_size<=63 gives max address 3968
// PORTS
//  SYS_CLK                          in   1     clock
//  SYS_NRST                         in   1     async reset, active low
//  fill_start                       in   1     1-cycle pulse; starts one map scan
//  pic_size                         in   6     map edge length
//  padding                          in   1     1 = zero border of width 1
//  fill_busy                        out  1     high from the accepted start until DONE exits
//  fill_done                        out  1     1-cycle pulse after the last beat is accepted
//  fill_err                         out  1     sticky error; cleared by the next accepted start
//  sram_rd_en                       out  1     SRAM read strobe; data returns 1 cycle later
//  sram_rd_addr                     out  AW    row*pic_size+col
//  sram_rd_data                     in   dw    SRAM read data
//  register_array_write_data        out  dw    beat data; zero when write_rst=1
//  register_array_write_enable      out  1     beat valid
//  register_array_write_addr_index  out  4     tap index 0..8
//  register_array_write_addr_bit    out  3     FIFO slot = window_cnt[2:0]
//  register_array_write_rst         out  1     beat is padding zero
//  register_array_write_size        out  4     constant 4'd9
//  register_array_write_resp        in   1     FIFO window-complete indication
//  register_array_full              in   1     FIFO full; a beat is accepted only when enable & ~full
// BEHAVIOUR
//  - Reset values: all outputs 0 except write_size=9. All counters 0. FSM in IDLE.
//  - N = pic_size-2+2*padding, computed 7-bit unsigned.
//  - Output rows r and cols c run 0..N-1, row-major. Each window emits taps ky, kx in order 0..2.
//  - Pixel coordinates: y = r+ky-padding, x = c+kx-padding.
//  - Pad tap: y or x outside 0..pic_size-1. Compare signed and widened, never wrapped.
//  - FSM:
//    - IDLE -> CALC on fill_start when N>=1. When N<1, fill_err=1 and the FSM stays in IDLE.
//    - CALC (1 cycle) -> RD for an image tap, or -> WR with write_rst=1 for a pad tap.
//    - RD: sram_rd_en=1 with the address. -> WR next cycle; capture sram_rd_data that cycle.
//    - WR: write_enable=1. Data, index, bit and rst stay stable while full=1.
//      - On enable & ~full the tap is accepted.
//      - If the tap is 8: window_cnt++. Then go to CALC for the next window, or DONE after window N*N-1.
//      - Otherwise go to CALC for the next tap.
//    - DONE: fill_done=1 for 1 cycle -> IDLE.
//  - Resp check: write_resp must be 1 exactly on the cycle tap 8 is accepted.
//    - resp=0 at tap-8 acceptance -> fill_err=1.
//    - resp=1 during any other accepted beat -> fill_err=1.
//    - The scan continues in both cases.
//  - fill_start while busy is ignored; config is latched on the accepted start.
//  - window_cnt is 12 bits; slot bit wraps 7->0 naturally.
//  - SYS_NRST low mid-scan: everything returns to reset values immediately. No partial window is completed.
//  - Throughput: 3 cycles per image beat, 2 per pad beat, with no backpressure.
// CONFIGURATION
//  REG_FILL_PAD_EN
//  - Defined: padding support as described above.
//  - Undefined: the padding input is ignored (treated as 0). No pad taps occur; write_rst is tied 0.
//    N = pic_size-2.
// TESTING
//  1. pic_size=4, padding=0, full=0, resp modelled per FIFO:
//     - 4 windows, 36 beats.
//     - Window0 addresses 0,1,2,4,5,6,8,9,10; window3 starts at address 5.
//     - Slot bits 0..3; fill_done once; fill_err=0.
//  2. pic_size=3, padding=1:
//     - 9 windows.
//     - Window0: taps 0,1,2,3,6 have write_rst=1 and no sram_rd_en; tap 4 address 0.
//     - Window8: taps 2,5,6,7,8 are rst.
//  3. Backpressure: full=1 for 5 cycles during the tap-4 WR state.
//     - write_enable held 1; data and index constant.
//     - No new sram_rd_en; the tap is accepted on the cycle full falls.
//  4. pic_size=6, padding=0 (16 windows): slot bit sequence 0..7,0..7. Start pulse mid-scan has no effect.
//  5. Assert SYS_NRST low during window 2 tap 5:
//     - Outputs return to reset values.
//     - A new start scans from window 0, bit 0.
//  6. Force resp=0 at a tap-8 acceptance: fill_err=1 and stays set until the next start. pic_size=2, padding=0: fill_err=1, busy never rises.
//  Also rerun test 2 with REG_FILL_PAD_EN undefined: N=1, one window with no rst beats.

Source files
------------

// File: rtl/register_array_filler.sv
// register_array_filler
// Write-side producer for the register-array FIFO of the input buffer.
// Scans a pic_size x pic_size feature map held in SRAM with a 3x3 stride-1
// window and emits every window as nine dw-bit beats (tap = ky*3+kx) into
// FIFO slot window_cnt[2:0]. Taps falling outside the image are sent as
// zero beats flagged by register_array_write_rst and are never read.
// Optional feature macro: REG_FILL_PAD_EN (zero border of width 1). When it
// is undefined the padding input is ignored and write_rst is tied low.
module register_array_filler #(
    parameter int dw = 128,
    parameter int AW = 12
) (
    input  logic          SYS_CLK,
    input  logic          SYS_NRST,
    input  logic          fill_start,
    input  logic [5:0]    pic_size,
    input  logic          padding,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          fill_err,
    output logic          sram_rd_en,
    output logic [AW-1:0] sram_rd_addr,
    input  logic [dw-1:0] sram_rd_data,
    output logic [dw-1:0] register_array_write_data,
    output logic          register_array_write_enable,
    output logic [3:0]    register_array_write_addr_index,
    output logic [2:0]    register_array_write_addr_bit,
    output logic          register_array_write_rst,
    output logic [3:0]    register_array_write_size,
    input  logic          register_array_write_resp,
    input  logic          register_array_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    // latched scan configuration
    logic [5:0]     pic_q;
    logic           pad_q;
    logic [6:0]     n_q;

    // scan position: output row/col, tap row/col, window counter
    logic [6:0]     row_q;
    logic [6:0]     col_q;
    logic [1:0]     ky_q;
    logic [1:0]     kx_q;
    logic [11:0]    window_cnt;

    // per-tap working registers
    logic           tap_pad_q;
    logic [AW-1:0]  rd_addr_q;
    logic           wr_first;
    logic [dw-1:0]  data_hold;
    logic           err_q;

    // combinational helpers
    logic           pad_in_eff;
    logic signed [7:0] n_calc;
    logic           n_ok;
    logic           start_ok;
    logic signed [8:0] y_s;
    logic signed [8:0] x_s;
    logic signed [8:0] pic_s;
    logic           tap_is_pad;
    logic [12:0]    addr_full;
    logic [3:0]     tap_idx;
    logic           last_tap;
    logic           last_col;
    logic           last_row;
    logic           accept;

`ifdef REG_FILL_PAD_EN
    assign pad_in_eff = padding;
`else
    assign pad_in_eff = padding & 1'b0;
`endif

    // Output edge length; evaluated signed so tiny maps give N<=0 instead of wrapping
    assign n_calc   = $signed({2'b00, pic_size}) + $signed({6'b000000, pad_in_eff, 1'b0}) - 8'sd2;
    assign n_ok     = !n_calc[7] && (n_calc != 8'sd0);
    assign start_ok = (state == S_IDLE) && fill_start && n_ok;

    // Pixel coordinates of the current tap, widened and signed for the bound check
    assign y_s   = $signed({2'b00, row_q}) + $signed({7'b0000000, ky_q}) - $signed({8'b00000000, pad_q});
    assign x_s   = $signed({2'b00, col_q}) + $signed({7'b0000000, kx_q}) - $signed({8'b00000000, pad_q});
    assign pic_s = $signed({3'b000, pic_q});

    assign tap_is_pad = (y_s < 9'sd0) || (y_s >= pic_s) || (x_s < 9'sd0) || (x_s >= pic_s);
    assign addr_full  = 13'(y_s[5:0]) * 13'(pic_q) + 13'(x_s[5:0]);

    assign tap_idx  = {2'b00, ky_q} * 4'd3 + {2'b00, kx_q};
    assign last_tap = (ky_q == 2'd2) && (kx_q == 2'd2);
    assign last_col = (col_q == n_q - 7'd1);
    assign last_row = (row_q == n_q - 7'd1);
    assign accept   = (state == S_WR) && !register_array_full;

    // State register
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: pad taps skip the SRAM read, backpressure holds WR
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                state_nxt = tap_is_pad ? S_WR : S_RD;
            end
            S_RD: begin
                state_nxt = S_WR;
            end
            S_WR: begin
                if (!register_array_full) begin
                    if (last_tap && last_row && last_col) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_CALC;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the map configuration once per accepted start
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            pic_q <= '0;
            pad_q <= 1'b0;
            n_q   <= '0;
        end else if (start_ok) begin
            pic_q <= pic_size;
            pad_q <= pad_in_eff;
            n_q   <= n_calc[6:0];
        end
    end

    // Walk taps, then columns, then rows; advance only on an accepted beat
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            row_q      <= '0;
            col_q      <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            window_cnt <= '0;
        end else if (start_ok) begin
            row_q      <= '0;
            col_q      <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            window_cnt <= '0;
        end else if (accept) begin
            if (kx_q != 2'd2) begin
                kx_q <= kx_q + 2'd1;
            end else begin
                kx_q <= '0;
                if (ky_q != 2'd2) begin
                    ky_q <= ky_q + 2'd1;
                end else begin
                    ky_q       <= '0;
                    window_cnt <= window_cnt + 12'd1;
                    if (!last_col) begin
                        col_q <= col_q + 7'd1;
                    end else begin
                        col_q <= '0;
                        row_q <= row_q + 7'd1;
                    end
                end
            end
        end
    end

    // Classify the tap and compute its SRAM address during CALC
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            tap_pad_q <= 1'b0;
            rd_addr_q <= '0;
        end else if (state == S_CALC) begin
            tap_pad_q <= tap_is_pad;
            if (!tap_is_pad) begin
                rd_addr_q <= AW'(addr_full);
            end
        end
    end

    // SRAM data is live only on the first WR cycle; hold it for backpressure
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            wr_first  <= 1'b0;
            data_hold <= '0;
        end else begin
            wr_first <= (state == S_RD);
            if ((state == S_WR) && wr_first) begin
                data_hold <= sram_rd_data;
            end
        end
    end

    // Sticky error: bad map size, or FIFO response not aligned with tap 8
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            err_q <= 1'b0;
        end else if ((state == S_IDLE) && fill_start) begin
            err_q <= !n_ok;
        end else if (accept && (register_array_write_resp != last_tap)) begin
            err_q <= 1'b1;
        end
    end

    assign fill_busy    = (state != S_IDLE);
    assign fill_done    = (state == S_DONE);
    assign fill_err     = err_q;
    assign sram_rd_en   = (state == S_RD);
    assign sram_rd_addr = rd_addr_q;

    assign register_array_write_enable     = (state == S_WR);
    assign register_array_write_addr_index = tap_idx;
    assign register_array_write_addr_bit   = window_cnt[2:0];
    assign register_array_write_size       = 4'd9;
    assign register_array_write_data       = ((state == S_WR) && !tap_pad_q) ?
                                             (wr_first ? sram_rd_data : data_hold) : '0;

`ifdef REG_FILL_PAD_EN
    assign register_array_write_rst = (state == S_WR) && tap_pad_q;
`else
    assign register_array_write_rst = 1'b0;
`endif

endmodule
